alu_mul_seq: RTL

- Iterative unsigned shift-and-add multiplier controller that sequences the shared ALU (ctrlSig/op1/op2 → aluOut/carry) for Width steps, one step per cycle, to form a 2*Width-bit product.
- Also arbitrates ALU ownership: the core datapath drives the ALU while the sequencer is idle, and the sequencer takes the ALU while a multiply runs.
- Sits beside the ALU in the execute stage.

---
 rtl/alu_mul_seq_if.sv | 42 ++++
 rtl/alu_mul_seq.sv | 114 +++++++++++
 2 files changed

// File: rtl/alu_mul_seq_if.sv
// Bundle of multiply handshake, core ALU request and shared-ALU connections
// for the iterative multiplier sequencer.
interface alu_mul_seq_if #(
    parameter int unsigned Width = 8
);
    logic               start;
    logic [Width-1:0]   mul_a;
    logic [Width-1:0]   mul_b;
    logic               busy;
    logic               done;
    logic [2*Width-1:0] product;

    logic               core_req;
    logic [3:0]         core_ctrl;
    logic [Width-1:0]   core_op1;
    logic [Width-1:0]   core_op2;
    logic               core_stall;

    logic [3:0]         alu_ctrl;
    logic [Width-1:0]   alu_op1;
    logic [Width-1:0]   alu_op2;
    logic [Width-1:0]   alu_out;
    logic               alu_carry;

    // Sequencer side.
    modport slave (
        input  start, mul_a, mul_b,
        input  core_req, core_ctrl, core_op1, core_op2,
        input  alu_out, alu_carry,
        output busy, done, product, core_stall,
        output alu_ctrl, alu_op1, alu_op2
    );

    // Core / ALU side.
    modport master (
        output start, mul_a, mul_b,
        output core_req, core_ctrl, core_op1, core_op2,
        output alu_out, alu_carry,
        input  busy, done, product, core_stall,
        input  alu_ctrl, alu_op1, alu_op2
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier that borrows the shared ALU for Width add
// steps and otherwise passes the core's ALU request straight through.
module alu_mul_seq #(
    parameter int unsigned Width    = 8,
    parameter logic [3:0]  ADD_CODE = 4'd2
) (
    input logic          clk,
    input logic          rst,
    alu_mul_seq_if.slave bus_io
);

    localparam int unsigned CntW = $clog2(Width) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(Width - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [Width-1:0]   mcand_q, mcand_d;
    logic [Width-1:0]   hi_q, hi_d;
    logic [Width-1:0]   lo_q, lo_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [2*Width-1:0] product_q, product_d;

    logic [Width-1:0]   step_sum;
    logic               step_carry;
    logic [Width-1:0]   step_hi;
    logic [Width-1:0]   step_lo;
    logic               busy;

    assign busy = (state_q == StRun);

    // Add only when the current multiplier bit is set; the ALU result is ignored otherwise.
    assign step_sum   = lo_q[0] ? bus_io.alu_out : hi_q;
    assign step_carry = lo_q[0] & bus_io.alu_carry;
    assign step_hi    = {step_carry, step_sum[Width-1:1]};
    assign step_lo    = {step_sum[0], lo_q[Width-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        product_d = product_q;

        unique case (state_q)
            StIdle: begin
                if (bus_io.start) begin
                    mcand_d = bus_io.mul_a;
                    lo_d    = bus_io.mul_b;
                    hi_d    = '0;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LastCnt) begin
                    // Capture on the final step so the product is already valid during DONE.
                    product_d = {step_hi, step_lo};
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        if (busy) begin
            bus_io.alu_ctrl = ADD_CODE;
            bus_io.alu_op1  = hi_q;
            bus_io.alu_op2  = mcand_q;
        end else begin
            bus_io.alu_ctrl = bus_io.core_ctrl;
            bus_io.alu_op1  = bus_io.core_op1;
            bus_io.alu_op2  = bus_io.core_op2;
        end
    end

    assign bus_io.busy       = busy;
    assign bus_io.done       = (state_q == StDone);
    assign bus_io.product    = product_q;
    assign bus_io.core_stall = bus_io.core_req & busy;

endmodule
